// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC bus master: address geometry, FSM states and
// region-aware address helpers.
package cdc_pkg;

  localparam int ADDR_W  = 6;
  localparam int REG_SEL = 5;
  localparam int RAM_AW  = 5;
  localparam int REG_AW  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAPT,
    RD_HOLD,
    FIN
  } state_t;

  // Next beat address, wrapping inside the RAM window or the 8-entry register window.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    if (a[REG_SEL]) begin
      r = {1'b1, {(REG_SEL-REG_AW){1'b0}}, REG_AW'(a[REG_AW-1:0] + 1'b1)};
    end else begin
      r = {1'b0, RAM_AW'(a[RAM_AW-1:0] + 1'b1)};
    end
    return r;
  endfunction

  function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
    return a[REG_SEL] && (a[REG_SEL-1:REG_AW] != '0);
  endfunction

endpackage

// File: rtl/cdc_addr_gen.sv
// Combinational next-address generator for burst beats.
module cdc_addr_gen
  import cdc_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt
);

  assign addr_nxt = addr_inc(addr);

endmodule

// File: rtl/cdc_bus_master.sv
// Burst command master for the CDC decoder bus: converts write/read bursts
// into single-cycle bus accesses with fully registered outputs.
module cdc_bus_master
  import cdc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [4:0]          req_len,
  input  logic                wd_valid,
  input  logic [DATA_W-1:0]   wd_data,
  output logic                wd_ready,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                rd_ready,
  output logic [ADDR_W-1:0]   CDC_A,
  output logic                CDC_wr,
  output logic [DATA_W-1:0]   CDC_D,
  input  logic [DATA_W-1:0]   CDC_Q,
  output logic                done,
  output logic                err
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n, addr_nxt;
  logic [4:0]          cnt, cnt_n;
  logic                ill, ill_n;
  logic [ADDR_W-1:0]   cdc_a_n;
  logic                cdc_wr_n;
  logic [DATA_W-1:0]   cdc_d_n;
  logic [DATA_W-1:0]   rd_data_n;
  logic                hs_req, hs_wd, hs_rd;

  cdc_addr_gen u_addr_gen (
    .addr     (addr),
    .addr_nxt (addr_nxt)
  );

  assign hs_req = req_valid && req_ready;
  assign hs_wd  = (state == WR) && wd_valid && wd_ready;
  assign hs_rd  = (state == RD_HOLD) && rd_valid && rd_ready;

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    cnt_n     = cnt;
    ill_n     = ill;
    cdc_a_n   = '0;
    cdc_wr_n  = 1'b0;
    cdc_d_n   = '0;
    rd_data_n = rd_data;
    unique case (state)
      IDLE: begin
        if (hs_req) begin
          addr_n = req_addr;
          cnt_n  = req_len;
          ill_n  = addr_illegal(req_addr);
          if (req_wr) begin
            state_n = WR;
          end else begin
            state_n = RD_ADDR;
            // The first read address must be on the bus during RD_ADDR itself.
            if (!ill_n) cdc_a_n = req_addr;
          end
        end
      end
      WR: begin
        if (ill) begin
          state_n = FIN;
        end else if (hs_wd) begin
          cdc_a_n  = addr;
          cdc_d_n  = wd_data;
          cdc_wr_n = 1'b1;
          addr_n   = addr_nxt;
          if (cnt == 5'd0) state_n = FIN;
          else             cnt_n   = cnt - 5'd1;
        end
      end
      RD_ADDR: begin
        if (ill) begin
          state_n = FIN;
        end else begin
          state_n = RD_CAPT;
          addr_n  = addr_nxt;
        end
      end
      RD_CAPT: begin
        state_n   = RD_HOLD;
        rd_data_n = CDC_Q;
      end
      RD_HOLD: begin
        if (hs_rd) begin
          if (cnt == 5'd0) begin
            state_n = FIN;
          end else begin
            cnt_n   = cnt - 5'd1;
            state_n = RD_ADDR;
            cdc_a_n = addr;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered state and outputs, each output derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      ill       <= 1'b0;
      req_ready <= 1'b0;
      wd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      CDC_A     <= '0;
      CDC_wr    <= 1'b0;
      CDC_D     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      ill       <= ill_n;
      req_ready <= (state_n == IDLE);
      wd_ready  <= (state_n == WR) && !ill_n;
      rd_valid  <= (state_n == RD_HOLD);
      rd_data   <= rd_data_n;
      CDC_A     <= cdc_a_n;
      CDC_wr    <= cdc_wr_n;
      CDC_D     <= cdc_d_n;
      done      <= (state_n == FIN);
      err       <= (state_n == FIN) && ill_n;
    end
  end

endmodule
